// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the MEM stage.
// Optional macro ARB_FAIR_EN: alternate grants when both requesters are pending.
module fetch_mem_arbiter #(
   parameter int unsigned W     = 32,
   parameter int unsigned SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [W-1:0]     if_addr,
   input  logic             flush,
   output logic [W-1:0]     if_inst,
   output logic             if_done,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [W-1:0]     d_addr,
   input  logic [W-1:0]     d_wdata,
   input  logic [SEL_W-1:0] d_sel,
   output logic [W-1:0]     d_rdata,
   output logic             d_done,
   output logic             stall_if,
   output logic             stall_d,
   output logic             m_ce,
   output logic             m_we,
   output logic [W-1:0]     m_addr,
   output logic [W-1:0]     m_wdata,
   output logic [SEL_W-1:0] m_sel,
   input  logic [W-1:0]     m_rdata,
   input  logic             m_ready
);

   typedef enum logic [1:0] {StIdle, StGntD, StGntI} state_e;

   state_e           state_q, state_d;
   logic             m_ce_q, m_ce_d;
   logic             m_we_q, m_we_d;
   logic [W-1:0]     m_addr_q, m_addr_d;
   logic [W-1:0]     m_wdata_q, m_wdata_d;
   logic [SEL_W-1:0] m_sel_q, m_sel_d;
   logic [W-1:0]     if_inst_q, if_inst_d;
   logic             if_done_q, if_done_d;
   logic [W-1:0]     d_rdata_q, d_rdata_d;
   logic             d_done_q, d_done_d;
   logic             drop_q, drop_d;
   logic             fetch_win, data_win;

`ifdef ARB_FAIR_EN
   logic last_was_d_q, last_was_d_d;

   // After a data grant the fetch gets the next contested slot.
   assign fetch_win = if_req & ~flush & (~d_req | last_was_d_q);
`else
   assign fetch_win = if_req & ~flush & ~d_req;
`endif
   assign data_win = d_req & ~fetch_win;

   always_comb begin
      state_d   = state_q;
      m_ce_d    = m_ce_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_sel_d   = m_sel_q;
      if_inst_d = if_inst_q;
      if_done_d = 1'b0;
      d_rdata_d = d_rdata_q;
      d_done_d  = 1'b0;
      drop_d    = drop_q;
`ifdef ARB_FAIR_EN
      last_was_d_d = last_was_d_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (fetch_win) begin
               state_d  = StGntI;
               m_ce_d   = 1'b1;
               m_we_d   = 1'b0;
               m_addr_d = if_addr;
               m_sel_d  = '1;
`ifdef ARB_FAIR_EN
               last_was_d_d = 1'b0;
`endif
            end else if (data_win) begin
               state_d   = StGntD;
               m_ce_d    = 1'b1;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_sel_d   = d_sel;
`ifdef ARB_FAIR_EN
               last_was_d_d = 1'b1;
`endif
            end
         end
         StGntD: begin
            if (m_ready) begin
               d_rdata_d = m_rdata;
               d_done_d  = 1'b1;
               m_ce_d    = 1'b0;
               state_d   = StIdle;
            end
         end
         StGntI: begin
            if (flush) drop_d = 1'b1;
            if (m_ready) begin
               // A flush in the completing cycle also makes the word stale.
               if (!(drop_q || flush)) begin
                  if_inst_d = m_rdata;
                  if_done_d = 1'b1;
               end
               drop_d  = 1'b0;
               m_ce_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         m_ce_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_sel_q   <= '0;
         if_inst_q <= '0;
         if_done_q <= 1'b0;
         d_rdata_q <= '0;
         d_done_q  <= 1'b0;
         drop_q    <= 1'b0;
`ifdef ARB_FAIR_EN
         last_was_d_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         m_ce_q    <= m_ce_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_sel_q   <= m_sel_d;
         if_inst_q <= if_inst_d;
         if_done_q <= if_done_d;
         d_rdata_q <= d_rdata_d;
         d_done_q  <= d_done_d;
         drop_q    <= drop_d;
`ifdef ARB_FAIR_EN
         last_was_d_q <= last_was_d_d;
`endif
      end
   end

   assign m_ce     = m_ce_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign m_sel    = m_sel_q;
   assign if_inst  = if_inst_q;
   assign if_done  = if_done_q;
   assign d_rdata  = d_rdata_q;
   assign d_done   = d_done_q;
   assign stall_d  = d_req & ~d_done_q;
   assign stall_if = (if_req & ~if_done_q) | stall_d;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Randomised bench for fetch_mem_arbiter with a transaction-level reference model.
module tb_fetch_mem_arbiter;
   localparam int unsigned W = 32;
   localparam int unsigned SEL_W = 4;
`ifdef ARB_FAIR_EN
   localparam bit Fair = 1'b1;
`else
   localparam bit Fair = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, if_req, flush, d_req, d_we, m_ready;
   logic [W-1:0] if_addr, d_addr, d_wdata, m_rdata;
   logic [SEL_W-1:0] d_sel;
   logic [W-1:0] if_inst, d_rdata, m_addr, m_wdata;
   logic [SEL_W-1:0] m_sel;
   logic if_done, d_done, stall_if, stall_d, m_ce, m_we;

   fetch_mem_arbiter #(.W(W), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
      .if_inst(if_inst), .if_done(if_done), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel), .d_rdata(d_rdata),
      .d_done(d_done), .stall_if(stall_if), .stall_d(stall_d), .m_ce(m_ce),
      .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model: the outstanding transaction and what the requesters must observe.
   int           txn;          // 0 none, 1 data access, 2 fetch
   bit           txn_dropped;
   bit           prev_was_data;
   logic         exp_ce, exp_we, exp_if_done, exp_d_done;
   logic [W-1:0] exp_addr, exp_wdata, exp_inst, exp_rdata;
   logic [SEL_W-1:0] exp_sel;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_next();
      bit take_fetch;
      if (rst) begin
         txn = 0; txn_dropped = 0; prev_was_data = 0;
         exp_ce = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_sel = '0;
         exp_inst = '0; exp_rdata = '0; exp_if_done = 0; exp_d_done = 0;
         return;
      end
      exp_if_done = 0;
      exp_d_done  = 0;
      if (txn == 0) begin
         take_fetch = if_req && !flush && (!d_req || (Fair && prev_was_data));
         if (take_fetch) begin
            txn = 2; prev_was_data = 0;
            exp_ce = 1; exp_we = 0; exp_addr = if_addr; exp_sel = '1;
         end else if (d_req) begin
            txn = 1; prev_was_data = 1;
            exp_ce = 1; exp_we = d_we; exp_addr = d_addr; exp_wdata = d_wdata; exp_sel = d_sel;
         end
      end else if (txn == 1) begin
         if (m_ready) begin
            exp_rdata = m_rdata; exp_d_done = 1; exp_ce = 0; txn = 0;
         end
      end else begin
         if (flush) txn_dropped = 1;
         if (m_ready) begin
            if (!txn_dropped) begin
               exp_inst = m_rdata; exp_if_done = 1;
            end
            txn_dropped = 0; exp_ce = 0; txn = 0;
         end
      end
   endtask

   // One clock: check stalls against current inputs, advance model, check registered outputs.
   task automatic step();
      logic e_sd, e_si;
      #1;
      e_sd = d_req && !exp_d_done;
      e_si = (if_req && !exp_if_done) || e_sd;
      chk("stall_d", 32'(stall_d), 32'(e_sd));
      chk("stall_if", 32'(stall_if), 32'(e_si));
      model_next();
      @(posedge clk);
      #1;
      chk("m_ce", 32'(m_ce), 32'(exp_ce));
      chk("if_done", 32'(if_done), 32'(exp_if_done));
      chk("d_done", 32'(d_done), 32'(exp_d_done));
      chk("if_inst", if_inst, exp_inst);
      chk("d_rdata", d_rdata, exp_rdata);
      if (exp_ce) begin
         chk("m_addr", m_addr, exp_addr);
         chk("m_we", 32'(m_we), 32'(exp_we));
         chk("m_sel", 32'(m_sel), 32'(exp_sel));
         if (exp_we) chk("m_wdata", m_wdata, exp_wdata);
      end
   endtask

   task automatic idle_inputs();
      if_req = 0; flush = 0; d_req = 0; d_we = 0; m_ready = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0; m_rdata = '0;
   endtask

   int n_if, n_d;

   initial begin
      txn = 0; txn_dropped = 0; prev_was_data = 0;
      idle_inputs();
      rst = 1;
      step(); step();
      rst = 0;
      chk("reset m_ce", 32'(m_ce), 32'd0);
      chk("reset m_addr", m_addr, 32'd0);
      chk("reset if_inst", if_inst, 32'd0);

      // Single fetch
      if_req = 1; if_addr = 32'h0;
      step();
      chk("fetch m_ce", 32'(m_ce), 32'd1);
      chk("fetch m_we", 32'(m_we), 32'd0);
      chk("fetch stall_if", 32'(stall_if), 32'd1);
      m_ready = 1; m_rdata = 32'h24010005;
      step();
      chk("fetch if_done", 32'(if_done), 32'd1);
      chk("fetch if_inst", if_inst, 32'h24010005);
      if_req = 0; m_ready = 0;
      step();

      // Store with wait states
      d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_sel = 4'hF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("store m_addr", m_addr, 32'h100);
         chk("store m_wdata", m_wdata, 32'hDEADBEEF);
         chk("store stall_if", 32'(stall_if), 32'd1);
         chk("store d_done", 32'(d_done), 32'd0);
      end
      m_ready = 1;
      step();
      chk("store d_done", 32'(d_done), 32'd1);
      d_req = 0; d_we = 0; m_ready = 0;
      step();

      // Collision: data wins unless fairness hands the slot to fetch
      d_req = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h8;
      step();
      chk("collide first addr", m_addr, Fair ? 32'h8 : 32'h200);
      m_ready = 1; m_rdata = Fair ? 32'hCAFE0003 : 32'h0BADF00D;
      step();
      chk("collide first done", 32'(Fair ? if_done : d_done), 32'd1);
      if (Fair) if_req = 0; else d_req = 0;
      m_ready = 0;
      step();
      chk("collide second addr", m_addr, Fair ? 32'h200 : 32'h8);
      m_ready = 1; m_rdata = Fair ? 32'h0BADF00D : 32'hCAFE0003;
      step();
      chk("collide if_inst", if_inst, 32'hCAFE0003);
      chk("collide d_rdata", d_rdata, 32'h0BADF00D);
      idle_inputs();
      step();

      // Flush during fetch
      if_req = 1; if_addr = 32'h10;
      step();
      flush = 1;
      step();
      flush = 0; m_ready = 1; m_rdata = 32'h1234;
      step();
      chk("flush if_done", 32'(if_done), 32'd0);
      chk("flush if_inst", if_inst, 32'hCAFE0003);
      chk("flush m_ce", 32'(m_ce), 32'd0);
      if_addr = 32'h40; m_ready = 0;
      step();
      chk("refetch m_addr", m_addr, 32'h40);
      m_ready = 1; m_rdata = 32'h55;
      step();
      chk("refetch if_inst", if_inst, 32'h55);
      idle_inputs();
      step();

      // Reset mid-transaction
      d_req = 1; d_addr = 32'h300;
      step();
      rst = 1;
      step();
      chk("midrst m_ce", 32'(m_ce), 32'd0);
      chk("midrst d_done", 32'(d_done), 32'd0);
      chk("midrst if_inst", if_inst, 32'd0);
      rst = 0; d_req = 0;
      step();

      // Starvation: data held high with fetch pending
      d_req = 1; if_req = 1; m_ready = 1;
      n_if = 0; n_d = 0;
      for (int i = 0; i < 12; i++) begin
         d_addr = $urandom; if_addr = $urandom; m_rdata = $urandom;
         step();
         n_if += int'(if_done);
         n_d  += int'(d_done);
      end
      chk("starve if_done count", 32'(n_if), Fair ? 32'd3 : 32'd0);
      chk("starve d_done count", 32'(n_d), Fair ? 32'd3 : 32'd6);
      idle_inputs();
      step();

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         rst     = ($urandom_range(0, 99) == 0);
         d_req   = ($urandom_range(0, 99) < 40);
         if_req  = ($urandom_range(0, 99) < 60);
         flush   = ($urandom_range(0, 99) < 10);
         m_ready = ($urandom_range(0, 99) < 40);
         d_we    = $urandom_range(0, 1) == 1;
         d_addr  = $urandom; d_wdata = $urandom; if_addr = $urandom; m_rdata = $urandom;
         d_sel   = 4'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Arbitrates one unified single-port memory between the instruction-fetch stage (PC/fetch) and the data-access (MEM) stage.
- Sequences multi-cycle memory transactions with a ready handshake.
- Drives the stall signals that freeze the PC and the MEM stage while a requester waits.
- Flush from the branch-resolve logic cancels an in-flight fetch so stale instructions are never delivered.

Parameters:
- W, 32, address/data word width.
- SEL_W, 4, byte-select width (W/8).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch stage requests an instruction word.
- if_addr  in  W  fetch address (current pc).
- flush  in  1  pipeline flush; cancels the current/pending fetch.
- if_inst  out  W  fetched instruction; valid when if_done.
- if_done  out  1  one-cycle pulse: if_inst valid.
- d_req  in  1  MEM stage requests a data access.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  W  data address.
- d_wdata  in  W  store data.
- d_sel  in  SEL_W  byte enables.
- d_rdata  out  W  load data; valid when d_done.
- d_done  out  1  one-cycle pulse: data access complete.
- stall_if  out  1  freeze PC/fetch stage.
- stall_d  out  1  freeze MEM stage and everything upstream of it.
- m_ce  out  1  memory chip enable.
- m_we  out  1  memory write enable.
- m_addr  out  W  memory address.
- m_wdata  out  W  memory write data.
- m_sel  out  SEL_W  memory byte enables.
- m_rdata  in  W  memory read data.
- m_ready  in  1  memory completes the access this cycle.

Behaviour:
- Reset: state=IDLE. All outputs are 0: if_inst, if_done, d_rdata, d_done, m_ce, m_we, m_addr, m_wdata, m_sel, and the drop flag.
- States:
  - IDLE: no transaction.
  - GNT_D: data transaction outstanding.
  - GNT_I: fetch transaction outstanding.
- Arbitration in IDLE:
  - Priority: d_req beats if_req (the older instruction must progress).
  - On grant, register the winner's request onto m_* with m_ce=1, and go to GNT_D or GNT_I. The memory sees the request starting the next cycle.
  - A fetch grant forces m_we=0 and m_sel=all ones.
- GNT_x:
  - Hold m_* stable until m_ready=1.
  - On m_ready:
    - Register m_rdata into d_rdata or if_inst.
    - Pulse d_done or if_done for one cycle.
    - Deassert m_ce and return to IDLE.
  - Minimum latency from request to done is 2 cycles (m_ready in the first GNT cycle). There is always at least one IDLE cycle between transactions.
- Stalls are combinational from state and requests:
  - stall_d = d_req & ~d_done.
  - stall_if = (if_req & ~if_done) | stall_d.
- Flush:
  - In GNT_I: the memory access is not aborted; a drop flag is set. On m_ready, if_done stays 0, if_inst is unchanged, and the flag clears.
  - In IDLE with if_req: no fetch is granted that cycle. A data grant is still allowed.
  - In GNT_D: no effect.
- Simultaneous d_req and if_req: data is served first. The fetch is served in the next IDLE if still requested.
- Request dropped mid-transaction (req falls in GNT_x): the transaction completes. The done pulse is still issued and is ignored by the requester.
- m_ready while IDLE is ignored.
- Reset asserted mid-transaction: immediate return to IDLE, outputs cleared, no done pulse.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined: a 1-bit last_was_d flag, set on each data grant and cleared on each fetch grant. In IDLE with both requests pending and last_was_d=1, the fetch wins. This guarantees a fetch at least every second transaction.
- Undefined: strict data priority as above; the flag is not present.

Test Plan:
- Reset then single fetch:
  - rst 2 cycles, if_req=1, if_addr=0x0, m_ready asserted 1 cycle after m_ce rises, m_rdata=0x24010005.
  - Expect m_ce=1, m_addr=0x0, m_we=0.
  - Expect if_done pulse with if_inst=0x24010005, 2 cycles after request.
  - Expect stall_if high until then.
- Store with wait states:
  - d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_sel=0xF, m_ready delayed 3 cycles.
  - Expect m_* held stable 3 cycles, then d_done.
  - Expect stall_d and stall_if both high throughout.
- Collision:
  - d_req and if_req rise the same cycle.
  - Expect data granted first (m_addr=d_addr), d_done, one IDLE cycle, then fetch granted.
  - With ARB_FAIR_EN defined and a data grant immediately before, expect the fetch granted first.
- Flush during fetch:
  - flush=1 in GNT_I, m_ready the next cycle, m_rdata=0x1234.
  - Expect no if_done, if_inst unchanged, state returns to IDLE.
  - Next fetch to flush_addr=0x40 completes normally.
- Reset mid-transaction:
  - rst asserted in GNT_D before m_ready.
  - Expect next cycle: m_ce=0, d_done=0, state IDLE, all outputs zero.
- Starvation check:
  - d_req held high for 6 back-to-back loads.
  - Without ARB_FAIR_EN: if_done never pulses.
  - With ARB_FAIR_EN: fetch and data grants alternate.
